tdc_event_readout: RTL and testbench

- Downstream consumer of the TDC channel (TDC_dumb); sits between the TDC and the readout bus.
- On each TDC event it captures o_timestamp and o_pulseWidth into an internal FIFO, then pulses the TDC's i_clear.
- Presents stored events to the reader as two 32-bit words per event: timestamp first, then pulse width.
- Counts events lost to FIFO overflow.

---
 rtl/tdc_event_readout.sv | 132 +++++++++++++
 tb/tb_tdc_event_readout.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_event_readout.sv
// Event readout FIFO behind a TDC channel: captures timestamp/pulse width per event, clears the TDC,
// and serves each stored event as two 32-bit words. Optional macro TDC_READOUT_MINTOT_FILTER_EN drops short pulses.
module tdc_event_readout #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] MIN_TOT = 32'd4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_hasEvent,
    input  logic [31:0]                i_timestamp,
    input  logic [31:0]                i_pulseWidth,
    output logic                       o_clear,
    input  logic                       i_rd_en,
    output logic                       o_rd_valid,
    output logic [31:0]                o_rd_data,
    output logic                       o_rd_last,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [15:0]                o_overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            word_sel_q, word_sel_d;
    logic [15:0]     ovf_q, ovf_d;

    logic [63:0]     fifo_mem [DEPTH];
    logic [63:0]     head_entry;
    logic            wr_en;
    logic            keep_event;
    logic            full;
    logic            pop_word;
    logic            pop_entry;

`ifdef TDC_READOUT_MINTOT_FILTER_EN
    assign keep_event = (i_pulseWidth >= MIN_TOT);
`else
    logic unused_min_tot;
    assign unused_min_tot = ^MIN_TOT;
    assign keep_event     = 1'b1;
`endif

    assign full      = (level_q == LW'(DEPTH));
    assign pop_word  = i_rd_en && (level_q != '0);
    assign pop_entry = pop_word && word_sel_q;

    // Capture FSM: one capture per hasEvent assertion, then a one-cycle clear.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ovf_d   = ovf_q;
        o_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_hasEvent) begin
                    state_d = CLEAR;
                    if (keep_event) begin
                        if (!full) begin
                            wr_en = 1'b1;
                        end else if (ovf_q != 16'hFFFF) begin
                            ovf_d = ovf_q + 16'd1;
                        end
                    end
                end
            end
            CLEAR: begin
                o_clear = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!i_hasEvent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop_entry);
        level_d    = level_q + LW'(wr_en) - LW'(pop_entry);
        word_sel_d = word_sel_q;
        if (pop_word) begin
            word_sel_d = ~word_sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            word_sel_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            word_sel_q <= word_sel_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= {i_timestamp, i_pulseWidth};
        end
    end

    assign head_entry     = fifo_mem[rd_ptr_q];
    assign o_rd_valid     = (level_q != '0);
    assign o_rd_last      = word_sel_q;
    assign o_rd_data      = !o_rd_valid ? 32'd0 :
                            (word_sel_q ? head_entry[31:0] : head_entry[63:32]);
    assign o_level        = level_q;
    assign o_overflow_cnt = ovf_q;

endmodule

// File: tb/tb_tdc_event_readout.sv
// Directed bench for tdc_event_readout: queue-based event model checked every cycle, plus literal checks.
module tb_tdc_event_readout;

    localparam int          DEPTH   = 16;
    localparam logic [31:0] MIN_TOT = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_hasEvent;
    logic [31:0] i_timestamp;
    logic [31:0] i_pulseWidth;
    logic        o_clear;
    logic        i_rd_en;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_rd_last;
    logic [4:0]  o_level;
    logic [15:0] o_overflow_cnt;

    int n_checks = 0;
    int n_errors = 0;

    tdc_event_readout #(.DEPTH(DEPTH), .MIN_TOT(MIN_TOT)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_hasEvent     (i_hasEvent),
        .i_timestamp    (i_timestamp),
        .i_pulseWidth   (i_pulseWidth),
        .o_clear        (o_clear),
        .i_rd_en        (i_rd_en),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_rd_last      (o_rd_last),
        .o_level        (o_level),
        .o_overflow_cnt (o_overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of stored events, the word being presented, and the capture phase.
    logic [63:0] m_q[$];
    logic        m_wsel = 1'b0;
    logic [15:0] m_ovf  = 16'd0;
    int          m_phase = 0;  // 0 ready, 1 clearing, 2 waiting for hasEvent to drop

    always @(negedge clk) begin
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        do_write;
        logic        keep;
        logic        full;
        if (reset) begin
            m_q.delete();
            m_wsel  = 1'b0;
            m_ovf   = 16'd0;
            m_phase = 0;
        end
        exp_valid = (m_q.size() != 0);
        exp_data  = 32'd0;
        if (exp_valid) exp_data = m_wsel ? m_q[0][31:0] : m_q[0][63:32];
        check("cmp_valid", 64'(o_rd_valid), 64'(exp_valid));
        check("cmp_data",  64'(o_rd_data),  64'(exp_data));
        check("cmp_last",  64'(o_rd_last),  64'(exp_valid && m_wsel));
        check("cmp_level", 64'(o_level),    64'(m_q.size()));
        check("cmp_ovf",   64'(o_overflow_cnt), 64'(m_ovf));
        check("cmp_clear", 64'(o_clear),    64'(m_phase == 1));
        if (!reset) begin
            full     = (m_q.size() >= DEPTH);
            keep     = 1'b1;
`ifdef TDC_READOUT_MINTOT_FILTER_EN
            keep     = (i_pulseWidth >= MIN_TOT);
`endif
            do_write = 1'b0;
            if (m_phase == 0 && i_hasEvent) begin
                if (keep && !full) do_write = 1'b1;
                if (keep && full && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && !i_hasEvent) begin
                m_phase = 0;
            end
            if (i_rd_en && m_q.size() != 0) begin
                if (m_wsel) begin
                    void'(m_q.pop_front());
                    m_wsel = 1'b0;
                end else begin
                    m_wsel = 1'b1;
                end
            end
            if (do_write) m_q.push_back({i_timestamp, i_pulseWidth});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete event handshake: capture, clear cycle, release.
    task automatic send_event(input logic [31:0] ts, input logic [31:0] tot);
        i_hasEvent   = 1'b1;
        i_timestamp  = ts;
        i_pulseWidth = tot;
        tick();
        check("ev_clear_hi", 64'(o_clear), 64'd1);
        i_hasEvent = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (o_rd_valid && guard < 4 * DEPTH + 8) begin
            pop();
            guard++;
        end
        check("drain_empty", 64'(o_rd_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        i_hasEvent   = 1'b1;
        i_timestamp  = 32'hAAAA_0001;
        i_pulseWidth = 32'h0000_0011;
        i_rd_en      = 1'b0;

        // Reset with an event pending
        repeat (3) begin
            tick();
            check("rst_level", 64'(o_level), 64'd0);
            check("rst_clear", 64'(o_clear), 64'd0);
            check("rst_valid", 64'(o_rd_valid), 64'd0);
            check("rst_data",  64'(o_rd_data), 64'd0);
            check("rst_last",  64'(o_rd_last), 64'd0);
            check("rst_ovf",   64'(o_overflow_cnt), 64'd0);
        end
        reset = 1'b0;
        tick();
        check("post_rst_level", 64'(o_level), 64'd1);
        check("post_rst_clear", 64'(o_clear), 64'd1);
        check("post_rst_data",  64'(o_rd_data), 64'hAAAA_0001);
        i_hasEvent = 1'b0;
        tick();
        check("post_rst_clear_lo", 64'(o_clear), 64'd0);
        tick();
        drain();

        // Single event, two-word readout
        send_event(32'h0000_1234, 32'h0000_0050);
        check("single_level", 64'(o_level), 64'd1);
        check("single_w0",    64'(o_rd_data), 64'h1234);
        check("single_l0",    64'(o_rd_last), 64'd0);
        pop();
        check("single_w1",    64'(o_rd_data), 64'h50);
        check("single_l1",    64'(o_rd_last), 64'd1);
        pop();
        check("single_empty", 64'(o_level), 64'd0);

        // 18 events into a 16-deep FIFO
        for (int i = 0; i < 18; i++) send_event(32'h1000_0000 + i, 32'd100 + i);
        check("ovf_level", 64'(o_level), 64'd16);
        check("ovf_cnt",   64'(o_overflow_cnt), 64'd2);
        for (int i = 0; i < 16; i++) begin
            check("order_ts",  64'(o_rd_data), 64'(32'h1000_0000 + i));
            pop();
            check("order_tot", 64'(o_rd_data), 64'(32'd100 + i));
            pop();
        end
        check("order_empty", 64'(o_level), 64'd0);

        // hasEvent held high long after clear: exactly one capture
        i_hasEvent   = 1'b1;
        i_timestamp  = 32'hBEEF_0001;
        i_pulseWidth = 32'h0000_0020;
        tick();
        check("hold_clear", 64'(o_clear), 64'd1);
        repeat (5) begin
            tick();
            check("hold_level", 64'(o_level), 64'd1);
            check("hold_clear_lo", 64'(o_clear), 64'd0);
        end
        i_hasEvent = 1'b0;
        tick();
        i_hasEvent  = 1'b1;
        i_timestamp = 32'hBEEF_0002;
        tick();
        check("rearm_level", 64'(o_level), 64'd2);
        i_hasEvent = 1'b0;
        tick();
        tick();
        drain();

        // Full FIFO: write and word1 pop on the same edge
        for (int i = 0; i < 16; i++) send_event(32'h2000_0000 + i, 32'd8);
        pop();
        check("full_last", 64'(o_rd_last), 64'd1);
        i_hasEvent   = 1'b1;
        i_timestamp  = 32'hDEAD_0000;
        i_pulseWidth = 32'd9;
        i_rd_en      = 1'b1;
        tick();
        i_rd_en = 1'b0;
        check("full_pop_level", 64'(o_level), 64'd15);
        check("full_pop_ovf",   64'(o_overflow_cnt), 64'd3);
        check("full_pop_head",  64'(o_rd_data), 64'h2000_0001);
        i_hasEvent = 1'b0;
        tick();
        tick();

        // Reset mid-operation discards contents
        reset = 1'b1;
        tick();
        check("midrst_level", 64'(o_level), 64'd0);
        check("midrst_ovf",   64'(o_overflow_cnt), 64'd0);
        reset = 1'b0;
        tick();

`ifdef TDC_READOUT_MINTOT_FILTER_EN
        send_event(32'h3000_0003, 32'd3);
        check("filt_short_level", 64'(o_level), 64'd0);
        send_event(32'h3000_0004, 32'd4);
        check("filt_keep_level", 64'(o_level), 64'd1);
        check("filt_keep_ts",    64'(o_rd_data), 64'h3000_0004);
        check("filt_ovf",        64'(o_overflow_cnt), 64'd0);
        drain();
`else
        send_event(32'h3000_0003, 32'd3);
        check("nofilt_level", 64'(o_level), 64'd1);
        check("nofilt_ts",    64'(o_rd_data), 64'h3000_0003);
        drain();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
